// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC-3 instruction fetch front end.
// Optional halt detection is controlled by the LC3_HALT_DETECT_EN macro
// (used in lc3_fetch_unit.sv).
package lc3_fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 16;

    localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 16'h3000;
    // TRAP x25: the LC-3 HALT service call
    localparam logic [FETCH_DATA_W-1:0] HALT_INSTR       = 16'hF025;

    typedef enum logic [3:0] {
        BR   = 4'd0,
        ADD  = 4'd1,
        LD   = 4'd2,
        ST   = 4'd3,
        JSR  = 4'd4,
        AND  = 4'd5,
        LDR  = 4'd6,
        STR  = 4'd7,
        RTI  = 4'd8,
        NOT  = 4'd9,
        LDI  = 4'd10,
        STI  = 4'd11,
        JMP  = 4'd12,
        RES  = 4'd13,
        LEA  = 4'd14,
        TRAP = 4'd15
    } opcode_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } fetch_state_e;

    // Opcode lives in the top nibble of every LC-3 instruction
    function automatic opcode_e decode_opcode(input logic [FETCH_DATA_W-1:0] word);
        return opcode_e'(word[15:12]);
    endfunction

endpackage

// File: rtl/lc3_fetch_fifo.sv
// Small synchronous FIFO of fetch entries (PC + instruction) with flush.
// The head entry is presented combinationally and reads as zero when empty.
module lc3_fetch_fifo
    import lc3_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     slot_reg [DEPTH];
    logic [DEPTH-1:0] slot_we;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign count = count_reg;

    // Pop on empty is ignored; a push into a full FIFO is allowed only when
    // the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // One write enable per slot; a flush wins over a same-cycle push
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot_we
            assign slot_we[gi] = do_push && !flush && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Entry storage, no reset needed since the head is masked while empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                slot_reg[i] <= push_entry;
            end
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_entry = empty ? '0 : slot_reg[rd_ptr_reg];

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch front end: single outstanding req/ack read,
// buffered instructions with PCs, valid/ready to decode, redirect/flush.
// Optional macro LC3_HALT_DETECT_EN: stop issuing after a HALT (TRAP x25)
// word is enqueued until the next redirect.
module lc3_fetch_unit
    import lc3_fetch_pkg::*;
#(
    parameter int               ADDR_W    = 16,
    parameter int               DATA_W    = 16,
    parameter int               BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [3:0]        instr_opcode,
    output logic              halted
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e      state_reg;
    fetch_state_e      state_next;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [ADDR_W-1:0] mem_addr_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    logic              halt_block;
    logic              issue_ok;

`ifdef LC3_HALT_DETECT_EN
    logic halted_reg;

    // Latch a HALT once it is enqueued; a redirect always resumes fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted_reg <= 1'b0;
        end else if (redirect_valid) begin
            halted_reg <= 1'b0;
        end else if (fifo_push && (mem_rdata == HALT_INSTR)) begin
            halted_reg <= 1'b1;
        end
    end

    assign halt_block = halted_reg;
    assign halted     = halted_reg;
`else
    assign halt_block = 1'b0;
    assign halted     = 1'b0;
`endif

    // Issue is only decided from IDLE, where nothing is outstanding, so
    // buffered occupancy alone tells whether the next word will fit.
    assign issue_ok = !halt_block && (fifo_count < CNT_W'(BUF_DEPTH));

    // Fetch state, PC and request address registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            mem_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            mem_addr_reg <= mem_addr_next;
        end
    end

    // Next-state logic: issue, capture, and redirect handling
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        mem_addr_next = mem_addr_reg;
        fifo_push     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_pc;
                end else if (issue_ok) begin
                    state_next    = REQ;
                    mem_addr_next = fetch_pc_reg;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    // The read in flight belongs to the old path; if it has
                    // not returned yet, keep the request up and drop it later.
                    fetch_pc_next = redirect_pc;
                    state_next    = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack) begin
                    fifo_push     = !fifo_full;
                    fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
                    state_next    = IDLE;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_pc;
                end
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_req  = (state_reg == REQ) || (state_reg == DISCARD);
    assign mem_addr = mem_addr_reg;

    assign push_entry = '{pc: fetch_pc_reg, instr: mem_rdata};

    // A redirect flushes the buffer, which overrides any same-cycle dequeue
    assign fifo_pop = instr_valid && instr_ready && !redirect_valid;

    lc3_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign instr_valid  = !fifo_empty;
    assign instr        = head_entry.instr;
    assign instr_pc     = head_entry.pc;
    assign instr_opcode = decode_opcode(head_entry.instr);

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: directed scenarios, a behavioural
// model checked every cycle, and literal expectations per scenario.
module tb_lc3_fetch_unit;

    localparam int DEPTH = 2;
`ifdef LC3_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [3:0]  instr_opcode;
    logic        halted;

    always #5 clk = ~clk;

    lc3_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_opcode   (instr_opcode),
        .halted         (halted)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    int          mem_lat = 0;
    bit          halt_inject = 1'b0;
    logic [15:0] halt_addr = 16'h0000;

    logic [15:0] issued_q[$];
    int          issued_cyc_q[$];
    logic [15:0] accepted_q[$];
    logic [15:0] accepted_instr_q[$];

    // Behavioural model state
    logic [31:0] m_q[$];
    logic [15:0] m_pc = 16'h3000;
    logic [15:0] m_addr = 16'h0000;
    bit          m_busy = 1'b0;
    bit          m_drop = 1'b0;
    bit          m_halt = 1'b0;
    bit          m_init = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_inject && a == halt_addr) return 16'hF025;
        return {a[3:0], a[11:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory: ack after mem_lat waiting cycles of an active request
    initial begin : mem_proc
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_req) begin
                cnt = 0;
                mem_ack = 1'b0;
            end else if (cnt >= mem_lat) begin
                mem_ack = 1'b1;
                mem_rdata = mem_word(mem_addr);
                cnt = 0;
            end else begin
                mem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Model update at each rising edge from the inputs seen by the DUT
    initial begin : model_proc
        bit          r, ack, rdy, busy_old, halt_old;
        logic [15:0] rp, rd, pc_old;
        int          depth_now;
        forever begin
            @(posedge clk);
            cycle++;
            r   = redirect_valid;
            rp  = redirect_pc;
            ack = mem_ack;
            rd  = mem_rdata;
            rdy = instr_ready;
            if (instr_valid && instr_ready) begin
                accepted_q.push_back(instr_pc);
                accepted_instr_q.push_back(instr);
            end
            if (!rst_n) begin
                m_q.delete();
                m_pc   = 16'h3000;
                m_addr = 16'h0000;
                m_busy = 1'b0;
                m_drop = 1'b0;
                m_halt = 1'b0;
                m_init = 1'b1;
            end else begin
                pc_old    = m_pc;
                depth_now = m_q.size();
                busy_old  = m_busy;
                halt_old  = m_halt;
                if (m_q.size() > 0 && rdy && !r) void'(m_q.pop_front());
                if (r) begin
                    m_q.delete();
                    m_pc   = rp;
                    m_halt = 1'b0;
                end
                if (busy_old) begin
                    if (ack) begin
                        if (!m_drop && !r) begin
                            m_q.push_back({pc_old, rd});
                            m_pc = pc_old + 16'h0001;
                            if (HALT_EN && rd == 16'hF025) m_halt = 1'b1;
                        end
                        m_busy = 1'b0;
                        m_drop = 1'b0;
                    end else if (r) begin
                        m_drop = 1'b1;
                    end
                end else if (!r && depth_now < DEPTH && !halt_old) begin
                    m_busy = 1'b1;
                    m_addr = pc_old;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus request logging
    initial begin : cmp_proc
        logic [31:0] exp;
        bit          prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (m_init) begin
                check("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
                if (m_busy) check("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
                check("instr_valid", {31'd0, instr_valid}, {31'd0, (m_q.size() > 0)});
                if (m_q.size() > 0 && instr_valid) begin
                    exp = m_q[0];
                    check("instr_pc", {16'd0, instr_pc}, {16'd0, exp[31:16]});
                    check("instr", {16'd0, instr}, {16'd0, exp[15:0]});
                    check("instr_opcode", {28'd0, instr_opcode}, {28'd0, exp[15:12]});
                end
                check("halted", {31'd0, halted}, {31'd0, m_halt});
            end
            if (mem_req && !prev_req) begin
                issued_q.push_back(mem_addr);
                issued_cyc_q.push_back(cycle);
            end
            prev_req = mem_req;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        halt_inject = 1'b0;
        tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", {16'd0, instr}, 32'd0);
        check("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        issued_q.delete();
        issued_cyc_q.delete();
        accepted_q.delete();
        accepted_instr_q.delete();
    endtask

    task automatic clear_logs();
        issued_q.delete();
        issued_cyc_q.delete();
        accepted_q.delete();
        accepted_instr_q.delete();
    endtask

    task automatic pulse_redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_issue(input logic [15:0] a, input int limit, input string name);
        int n;
        n = 0;
        while (!(mem_req && mem_addr == a) && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (!(mem_req && mem_addr == a)) begin
            bad++;
            $display("FAIL %s: no request at %h within %0d cycles (mem_req=%b mem_addr=%h)",
                     name, a, limit, mem_req, mem_addr);
        end
    endtask

    task automatic wait_logs(input int n_iss, input int n_acc, input int limit, input string name);
        int n;
        n = 0;
        while ((issued_q.size() < n_iss || accepted_q.size() < n_acc) && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (issued_q.size() < n_iss || accepted_q.size() < n_acc) begin
            bad++;
            $display("FAIL %s: timeout, issued=%0d accepted=%0d required %0d/%0d",
                     name, issued_q.size(), accepted_q.size(), n_iss, n_acc);
        end
    endtask

    task automatic check_issued(input int k, input logic [15:0] exp, input string name);
        if (issued_q.size() > k) check(name, {16'd0, issued_q[k]}, {16'd0, exp});
        else begin
            total++;
            bad++;
            $display("FAIL %s: issue #%0d missing, required %h", name, k, exp);
        end
    endtask

    task automatic check_accepted(input int k, input logic [15:0] exp, input string name);
        if (accepted_q.size() > k) check(name, {16'd0, accepted_q[k]}, {16'd0, exp});
        else begin
            total++;
            bad++;
            $display("FAIL %s: accept #%0d missing, required pc %h", name, k, exp);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        tick();

        // 1: zero-wait memory, decode always ready
        do_reset();
        mem_lat = 0;
        instr_ready = 1'b1;
        repeat (10) tick();
        check_issued(0, 16'h3000, "t1_addr0");
        check_issued(1, 16'h3001, "t1_addr1");
        check_issued(2, 16'h3002, "t1_addr2");
        if (issued_cyc_q.size() >= 3) begin
            check("t1_gap01", issued_cyc_q[1] - issued_cyc_q[0], 32'd2);
            check("t1_gap12", issued_cyc_q[2] - issued_cyc_q[1], 32'd2);
        end
        check_accepted(0, 16'h3000, "t1_pc0");
        check_accepted(1, 16'h3001, "t1_pc1");
        if (accepted_instr_q.size() > 1)
            check("t1_instr1", {16'd0, accepted_instr_q[1]}, 32'h0000_1001);

        // 2: decode stalled, buffer fills to two entries then drains in order
        do_reset();
        mem_lat = 0;
        instr_ready = 1'b0;
        repeat (12) tick();
        check("t2_nissued", issued_q.size(), 32'd2);
        check("t2_req_idle", {31'd0, mem_req}, 32'd0);
        check("t2_head_pc", {16'd0, instr_pc}, 32'h0000_3000);
        check("t2_head_op", {28'd0, instr_opcode}, 32'd0);
        instr_ready = 1'b1;
        repeat (10) tick();
        check_accepted(0, 16'h3000, "t2_drain0");
        check_accepted(1, 16'h3001, "t2_drain1");
        check_issued(2, 16'h3002, "t2_resume");

        // 3: redirect during a slow read at 3005
        do_reset();
        mem_lat = 3;
        instr_ready = 1'b1;
        wait_issue(16'h3005, 100, "t3_reach3005");
        pulse_redirect(16'h4000);
        check("t3_req_held", {31'd0, mem_req}, 32'd1);
        check("t3_addr_held", {16'd0, mem_addr}, 32'h0000_3005);
        check("t3_flushed", {31'd0, instr_valid}, 32'd0);
        clear_logs();
        wait_logs(1, 1, 40, "t3_restart");
        check_issued(0, 16'h4000, "t3_next_addr");
        check_accepted(0, 16'h4000, "t3_first_pc");

        // 4: redirect in the same cycle as the ack
        do_reset();
        mem_lat = 0;
        instr_ready = 1'b1;
        wait_issue(16'h3001, 20, "t4_reach3001");
        check("t4_ack_now", {31'd0, mem_ack}, 32'd1);
        pulse_redirect(16'h5000);
        check("t4_empty", {31'd0, instr_valid}, 32'd0);
        clear_logs();
        wait_logs(1, 1, 20, "t4_restart");
        check_issued(0, 16'h5000, "t4_next_addr");
        check_accepted(0, 16'h5000, "t4_first_pc");

        // 5: PC wraps past FFFF
        do_reset();
        mem_lat = 0;
        instr_ready = 1'b1;
        pulse_redirect(16'hFFFF);
        clear_logs();
        wait_logs(3, 3, 30, "t5_wrap");
        check_accepted(0, 16'hFFFF, "t5_pc0");
        check_accepted(1, 16'h0000, "t5_pc1");
        check_accepted(2, 16'h0001, "t5_pc2");

        // 6: HALT word returned at 3002
        do_reset();
        mem_lat = 0;
        instr_ready = 1'b1;
        halt_inject = 1'b1;
        halt_addr = 16'h3002;
        wait_issue(16'h3002, 20, "t6_reach3002");
        tick();
`ifdef LC3_HALT_DETECT_EN
        check("t6_halted", {31'd0, halted}, 32'd1);
        repeat (8) tick();
        check("t6_nissued", issued_q.size(), 32'd3);
        check("t6_req_stopped", {31'd0, mem_req}, 32'd0);
        if (accepted_instr_q.size() > 0)
            check("t6_halt_drained", {16'd0, accepted_instr_q[accepted_instr_q.size()-1]}, 32'h0000_F025);
        pulse_redirect(16'h3000);
        check("t6_unhalted", {31'd0, halted}, 32'd0);
        clear_logs();
        wait_logs(1, 0, 20, "t6_restart");
        check_issued(0, 16'h3000, "t6_restart_addr");
`else
        check("t6_not_halted", {31'd0, halted}, 32'd0);
        repeat (8) tick();
        check_issued(3, 16'h3003, "t6_continues");
        if (accepted_instr_q.size() > 2)
            check("t6_halt_word", {16'd0, accepted_instr_q[2]}, 32'h0000_F025);
`endif
        halt_inject = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_unit.md
Name: lc3_fetch_unit

Overview:
Instruction fetch front end for the LC-3 core. Issues word reads at the fetch PC over a req/ack memory port and buffers returned instructions with their PCs in a small FIFO. Presents one instruction per cycle, with its decoded opcode, to the decode stage over a valid/ready handshake. Supports PC redirect (branch/JSR/JMP/TRAP/RTI) with flush and discard of an in-flight read.

Parameters:
ADDR_W, 16, address and PC width
DATA_W, 16, instruction width
BUF_DEPTH, 2, instruction FIFO entries (power of two, >=2)
RESET_PC, 16'h3000, fetch PC after reset

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
redirect_valid  in  1  single-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch PC
mem_req  out  1  read request, held until mem_ack
mem_addr  out  ADDR_W  read address, stable while mem_req=1
mem_ack  in  1  one-cycle pulse, mem_rdata valid this cycle
mem_rdata  in  DATA_W  returned instruction word
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode accepts head
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  PC of head instruction
instr_opcode  out  4  instr[15:12], encoded as opcode_e
halted  out  1  halt detected (see Optional Feature); constant 0 when feature is off

Behaviour:
- Reset (rst_n=0 at clk edge): fetch_pc=RESET_PC, FIFO empty, state IDLE, mem_req=0, mem_addr=0, instr_valid=0, instr/instr_pc=0, halted=0.
- At most one outstanding read.
- States:
  - IDLE: mem_req=0. If no redirect this cycle and (FIFO occupancy + outstanding) < BUF_DEPTH, assert mem_req with mem_addr=fetch_pc next cycle and go to REQ.
  - REQ: mem_req=1. On mem_ack without redirect: push {fetch_pc, mem_rdata}, fetch_pc+=1, go to IDLE. The next request is issued no earlier than the cycle after the ack, so there is one bubble between reads.
  - DISCARD: mem_req stays 1 at the old address until mem_ack. Data is dropped, then go to IDLE.
- Redirect:
  - Flush FIFO (instr_valid=0 next cycle) and set fetch_pc=redirect_pc.
  - From IDLE: stay in IDLE; fetch resumes the following cycle.
  - From REQ with no ack in the same cycle: go to DISCARD.
  - From REQ with ack in the same cycle: data dropped, go to IDLE.
  - From DISCARD: stay in DISCARD and update fetch_pc.
  - Redirect overrides a same-cycle dequeue. The handshake is still considered complete if instr_ready=1.
- mem_req never drops before mem_ack, including across redirect.
- FIFO:
  - Push and pop may occur in the same cycle when full or empty.
  - Push into empty FIFO: instr_valid=1 on the next cycle (ack-to-valid latency = 1 cycle).
  - Pop when instr_valid & instr_ready.
  - instr/instr_pc/instr_opcode hold stable while instr_valid=1 and instr_ready=0.
- fetch_pc increments modulo 2^ADDR_W: 16'hFFFF -> 16'h0000.
- Full FIFO stalls issue; no overflow is possible. Pop on empty is ignored.
- Reset mid-request: mem_req drops at the reset edge. The memory model must tolerate an abandoned request.

Optional Feature:
Macro LC3_HALT_DETECT_EN.
- Defined:
  - When an enqueued word equals HALT_INSTR (16'hF025, TRAP x25), set halted=1 and suppress new request issue.
  - Any outstanding read still completes and is enqueued.
  - Already-buffered entries still drain.
  - redirect_valid clears halted and resumes fetch.
- Undefined: halted tied to 0; HALT words are fetched like any other instruction.

Decomposition:
- Package lc3_fetch_pkg:
  - opcode_e enum: BR=0, ADD, LD, ST, JSR, AND, LDR, STR, RTI, NOT, LDI, STI, JMP, RES, LEA, TRAP=15.
  - fetch_entry_t struct: pc[ADDR_W], instr[DATA_W].
  - fetch_state_e enum: IDLE, REQ, DISCARD.
  - Constants RESET_PC_DEFAULT, HALT_INSTR.
- Sub-module lc3_fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with flush, full/empty and count outputs.

Test Plan:
- Reset, then zero-wait memory and instr_ready=1 -> mem_addr sequence 3000,3001,3002, one read every 2 cycles; instr_pc matches and instr_opcode=instr[15:12].
- instr_ready=0 with fast memory -> exactly 2 entries buffered, then mem_req stays 0; raise instr_ready -> 3000 then 3001 drain in order, then fetch resumes at 3002.
- Redirect to 4000 while REQ at 3005 and mem_ack 3 cycles later -> mem_req held at 3005 until ack, data dropped, next mem_addr=4000, first instr_pc=4000.
- Redirect in the same cycle as mem_ack -> acked word not enqueued, FIFO empty, next request at redirect_pc.
- redirect_pc=FFFF -> instr_pc sequence FFFF, 0000, 0001.
- With LC3_HALT_DETECT_EN, memory returns F025 at 3002 -> halted=1 one cycle after the ack, no request at 3003; redirect to 3000 -> halted=0, fetch restarts at 3000.
